mlp_seq_ctrl: RTL and testbench



---
 rtl/mlp_seq_ctrl.sv | 114 +++++++++++
 tb/tb_mlp_seq_ctrl.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/mlp_seq_ctrl.sv
// Sequencer for the two-layer MLP: issues weight addresses and read enables, then emits
// clear/accumulate/bias strobes aligned to the memory's one-cycle read latency.
`timescale 1ns / 1ps
module mlp_seq_ctrl #(
  parameter int unsigned N_IN  = 784,
  parameter int unsigned N_HID = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        hold,
  output logic [31:0] ctr1,
  output logic [31:0] ctr2,
  output logic        re,
  output logic        l1_clr,
  output logic        l1_mac_en,
  output logic        l1_bias_en,
  output logic        l2_clr,
  output logic        l2_mac_en,
  output logic        l2_bias_en,
  output logic        busy,
  output logic        done
);

  localparam logic [9:0] NIn  = 10'(N_IN);
  localparam logic [9:0] NHid = 10'(N_HID);

  typedef enum logic [2:0] {
    StIdle, StL1, StL1Flush, StL2, StL2Flush, StDone
  } state_e;

  state_e     state_q, state_d;
  logic [9:0] ctr1_q, ctr1_d, ctr2_q, ctr2_d;
  logic       first_q, first_d;
  // Pipeline tracking what was issued last cycle, so strobes line up with memory data
  logic       iss_q;
  logic       lyr_q;
  logic [9:0] addr_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      ctr1_q  <= '0;
      ctr2_q  <= '0;
      first_q <= 1'b0;
      iss_q   <= 1'b0;
      lyr_q   <= 1'b0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      ctr1_q  <= ctr1_d;
      ctr2_q  <= ctr2_d;
      first_q <= first_d;
      iss_q   <= re;
      lyr_q   <= (state_q == StL2);
      addr_q  <= (state_q == StL2) ? ctr2_q : ctr1_q;
    end
  end

  always_comb begin
    state_d = state_q;
    ctr1_d  = ctr1_q;
    ctr2_d  = ctr2_q;
    first_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StL1;
          ctr1_d  = '0;
          first_d = 1'b1;
        end
      end
      StL1: begin
        if (!hold) begin
          if (ctr1_q == NIn) state_d = StL1Flush;
          else               ctr1_d  = ctr1_q + 10'd1;
        end
      end
      StL1Flush: begin
        state_d = StL2;
        ctr2_d  = '0;
        first_d = 1'b1;
      end
      StL2: begin
        if (!hold) begin
          if (ctr2_q == NHid) state_d = StL2Flush;
          else                ctr2_d  = ctr2_q + 10'd1;
        end
      end
      StL2Flush: begin
        state_d = StDone;
        ctr1_d  = '0;
        ctr2_d  = '0;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    re         = ((state_q == StL1) || (state_q == StL2)) && !hold;
    l1_clr     = (state_q == StL1) && first_q;
    l2_clr     = (state_q == StL2) && first_q;
    l1_mac_en  = iss_q && !lyr_q && (addr_q < NIn);
    l1_bias_en = iss_q && !lyr_q && (addr_q == NIn);
    l2_mac_en  = iss_q && lyr_q && (addr_q < NHid);
    l2_bias_en = iss_q && lyr_q && (addr_q == NHid);
    busy       = (state_q != StIdle) && (state_q != StDone);
    done       = (state_q == StDone);
    ctr1       = {22'd0, ctr1_q};
    ctr2       = {22'd0, ctr2_q};
  end

endmodule

// File: tb/tb_mlp_seq_ctrl.sv
// Scoreboard bench for mlp_seq_ctrl: a cycle-level event model fills an expectation queue,
// a negedge monitor pops and compares strobes, addresses and busy.
`timescale 1ns / 1ps
module tb_mlp_seq_ctrl;

  localparam int N_IN  = 784;
  localparam int N_HID = 32;

  logic clk = 1'b0;
  logic reset, start, hold, start_s;
  logic [31:0] ctr1, ctr2, s_ctr1, s_ctr2;
  logic re, l1_clr, l1_mac_en, l1_bias_en, l2_clr, l2_mac_en, l2_bias_en, busy, done;
  logic s_re, s_l1_clr, s_l1m, s_l1b, s_l2_clr, s_l2m, s_l2b, s_busy, s_done;

  always #5 clk = ~clk;

  mlp_seq_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .hold(hold), .ctr1(ctr1), .ctr2(ctr2), .re(re),
    .l1_clr(l1_clr), .l1_mac_en(l1_mac_en), .l1_bias_en(l1_bias_en), .l2_clr(l2_clr),
    .l2_mac_en(l2_mac_en), .l2_bias_en(l2_bias_en), .busy(busy), .done(done)
  );

  mlp_seq_ctrl #(.N_IN(4), .N_HID(2)) u_small (
    .clk(clk), .reset(reset), .start(start_s), .hold(1'b0), .ctr1(s_ctr1), .ctr2(s_ctr2),
    .re(s_re), .l1_clr(s_l1_clr), .l1_mac_en(s_l1m), .l1_bias_en(s_l1b), .l2_clr(s_l2_clr),
    .l2_mac_en(s_l2m), .l2_bias_en(s_l2b), .busy(s_busy), .done(s_done)
  );

  // Event bit: 0 re, 1 l1_clr, 2 l2_clr, 3 l1_mac, 4 l1_bias, 5 l2_mac, 6 l2_bias, 7 done
  typedef struct {
    int cyc;
    int b;
    int lay;
    int idx;
  } ev_t;

  ev_t exp_q[$];
  bit  hold_arr[4096];
  bit  xstart[4096];
  int  cyc = 0;
  int  n_checks = 0, n_fail = 0;
  int  busy_lo = 1, busy_hi = 0;
  int  done_off = 0, iss25_cyc = -1;
  bit  mon_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(input string name, input int act, input int expv);
    n_checks++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, expv, cyc);
    end
  endfunction

  function automatic void push_ev(input int c, input int b, input int lay, input int idx);
    ev_t e;
    int i;
    e.cyc = c; e.b = b; e.lay = lay; e.idx = idx;
    i = exp_q.size();
    while (i > 0 && (exp_q[i-1].cyc > c || (exp_q[i-1].cyc == c && exp_q[i-1].b > b))) i--;
    exp_q.insert(i, e);
  endfunction

  function automatic bit held(input int off);
    return (off < 4096) && hold_arr[off];
  endfunction

  // Each address is issued once, in the first non-held cycle; its strobe lands one cycle later.
  function automatic void model(input int T);
    int t;
    t = T + 1;
    push_ev(t, 1, 0, 0);
    for (int k = 0; k <= N_IN; k++) begin
      while (held(t - T)) t++;
      push_ev(t, 0, 1, k);
      push_ev(t + 1, (k < N_IN) ? 3 : 4, 0, 0);
      t++;
    end
    t++;
    push_ev(t, 2, 0, 0);
    for (int k = 0; k <= N_HID; k++) begin
      while (held(t - T)) t++;
      push_ev(t, 0, 2, k);
      if (k == 5) iss25_cyc = t;
      push_ev(t + 1, (k < N_HID) ? 5 : 6, 0, 0);
      t++;
    end
    push_ev(t + 1, 7, 0, 0);
    busy_lo  = T + 1;
    busy_hi  = t;
    done_off = t + 1 - T;
  endfunction

  always @(negedge clk) begin
    logic [7:0] obs, expm;
    ev_t e;
    int lay, idx;
    if (mon_en) begin
      obs  = {done, l2_bias_en, l2_mac_en, l1_bias_en, l1_mac_en, l2_clr, l1_clr, re};
      expm = '0;
      lay  = 0;
      idx  = 0;
      while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
        e = exp_q.pop_front();
        expm[e.b] = 1'b1;
        if (e.b == 0) begin
          lay = e.lay;
          idx = e.idx;
        end
      end
      if (obs != 0 || expm != 0) check("strobes", int'(obs), int'(expm));
      if (expm[0] && obs[0]) check((lay == 1) ? "ctr1" : "ctr2", (lay == 1) ? ctr1 : ctr2, idx);
      check("busy", int'(busy), int'(cyc >= busy_lo && cyc <= busy_hi));
      if (!busy) begin
        check("ctr1_idle", ctr1, 0);
        check("ctr2_idle", ctr2, 0);
      end
    end
  end

  int s_n1 = 0, s_n2 = 0, s_b1 = 0, s_b2 = 0, s_done_cyc = -1;
  bit s_en = 1'b0;
  always @(negedge clk) begin
    if (s_en) begin
      if (s_l1m) s_n1++;
      if (s_l2m) s_n2++;
      if (s_l1b) s_b1++;
      if (s_l2b) s_b2++;
      if (s_done) s_done_cyc = cyc;
    end
  end

  // hold_mode: 0 none, 1 directed (3 at ctr1=100, 1 at ctr2=32), 2 random
  task automatic run(input int hold_mode, input bit xs, input bit do_reset);
    int T;
    int r_off;
    r_off = -1;
    for (int i = 0; i < 4096; i++) begin
      hold_arr[i] = (hold_mode == 2) ? ($urandom_range(7) == 0) : 1'b0;
      xstart[i]   = xs && ($urandom_range(63) == 0);
    end
    if (hold_mode == 1) begin
      hold_arr[101] = 1'b1; hold_arr[102] = 1'b1; hold_arr[103] = 1'b1; hold_arr[822] = 1'b1;
    end
    T = cyc;
    model(T);
    if (xs) begin
      xstart[501]      = 1'b1;
      xstart[done_off] = 1'b1;
    end
    for (int o = 0; o <= done_off + 3; o++) begin
      start = (o == 0) || (xs && o <= done_off && xstart[o]);
      hold  = hold_arr[o];
      reset = 1'b0;
      if (do_reset && T + o == iss25_cyc) begin
        reset = 1'b1;
        r_off = o;
        while (exp_q.size() > 0 && exp_q[$].cyc > T + o) exp_q.pop_back();
        busy_hi = T + o;
      end
      if (r_off >= 0 && o > r_off) start = 1'b0;
      @(posedge clk); #1;
    end
    start = 1'b0;
    hold  = 1'b0;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    int ts;
    reset = 1'b1; start = 1'b0; hold = 1'b0; start_s = 1'b0;
    repeat (2) @(posedge clk);
    #1 mon_en = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    s_en = 1'b1;
    start_s = 1'b1;
    ts = cyc;
    @(posedge clk); #1 start_s = 1'b0;
    repeat (14) @(posedge clk);
    #1;
    check("small_done_cycle", s_done_cyc - ts, 11);
    check("small_l1_mac", s_n1, 4);
    check("small_l2_mac", s_n2, 2);
    check("small_l1_bias", s_b1, 1);
    check("small_l2_bias", s_b2, 1);
    check("small_idle", int'(s_busy), 0);

    run(0, 1'b0, 1'b0);
    run(1, 1'b0, 1'b0);
    run(0, 1'b1, 1'b0);
    run(2, 1'b1, 1'b0);
    run(2, 1'b0, 1'b0);
    run(2, 1'b0, 1'b1);
    run(0, 1'b0, 1'b0);

    check("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
